// File: rtl/rf_access_arbiter.sv
// Round-robin arbiter sharing the register-file software port between a host bridge (m0) and a
// debug master (m1). One access in flight; one-cycle RF strobe, completion wait with timeout.
module rf_access_arbiter #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned TO_W    = 7
) (
  input  logic                clk,
  input  logic                res_n,
  input  logic [1:0]          m_req,
  input  logic [1:0]          m_we,
  input  logic [2*ADDR_W-1:0] m_addr,
  input  logic [2*DATA_W-1:0] m_wdata,
  output logic [1:0]          m_ack,
  output logic [DATA_W-1:0]   m_rdata,
  output logic                m_err,
  output logic                m_tout,
  output logic                busy,
  output logic [ADDR_W-1:0]   rf_address,
  output logic                rf_read_en,
  output logic                rf_write_en,
  output logic [DATA_W-1:0]   rf_write_data,
  input  logic [DATA_W-1:0]   rf_read_data,
  input  logic                rf_invalid_address,
  input  logic                rf_access_complete
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e              r_state;
  state_e              w_state_next;

  logic                r_grant;
  logic                r_we;
  logic                r_last_grant;
  logic [TO_W-1:0]     r_cnt;
  logic [1:0]          r_ack;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic                r_tout;
  logic                r_busy;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_rd_en;
  logic                r_wr_en;
  logic [DATA_W-1:0]   r_wdata;

  logic                w_grant_d;
  logic                w_we_d;
  logic                w_last_grant_d;
  logic [TO_W-1:0]     w_cnt_d;
  logic [1:0]          w_ack_d;
  logic [DATA_W-1:0]   w_rdata_d;
  logic                w_err_d;
  logic                w_tout_d;
  logic                w_busy_d;
  logic [ADDR_W-1:0]   w_addr_d;
  logic                w_rd_en_d;
  logic                w_wr_en_d;
  logic [DATA_W-1:0]   w_wdata_d;

  logic                w_grant;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                w_timeout;
  logic [1:0]          w_ack_vec;

  // Single requester wins outright; on conflict the one not served last time wins.
  always_comb begin
    case (m_req)
      2'b01:   w_grant = 1'b0;
      2'b10:   w_grant = 1'b1;
      default: w_grant = ~r_last_grant;
    endcase
  end

  assign w_sel_we    = w_grant ? m_we[1] : m_we[0];
  assign w_sel_addr  = w_grant ? m_addr[2*ADDR_W-1:ADDR_W] : m_addr[ADDR_W-1:0];
  assign w_sel_wdata = w_grant ? m_wdata[2*DATA_W-1:DATA_W] : m_wdata[DATA_W-1:0];
  assign w_timeout   = (r_cnt == TO_W'(TIMEOUT - 1));
  assign w_ack_vec   = r_grant ? 2'b10 : 2'b01;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (|m_req) w_state_next = StIssue;
      StIssue: w_state_next = StWait;
      StWait:  if (rf_access_complete || w_timeout) w_state_next = StResp;
      StResp:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_grant_d      = r_grant;
    w_we_d         = r_we;
    w_last_grant_d = r_last_grant;
    w_cnt_d        = r_cnt;
    w_ack_d        = 2'b00;
    w_rdata_d      = r_rdata;
    w_err_d        = r_err;
    w_tout_d       = r_tout;
    w_addr_d       = r_addr;
    w_wdata_d      = r_wdata;
    w_rd_en_d      = 1'b0;
    w_wr_en_d      = 1'b0;
    w_busy_d       = (w_state_next != StIdle);
    unique case (r_state)
      StIdle: begin
        if (|m_req) begin
          w_grant_d      = w_grant;
          w_last_grant_d = w_grant;
          w_we_d         = w_sel_we;
          w_addr_d       = w_sel_addr;
          w_wdata_d      = w_sel_wdata;
          w_rd_en_d      = ~w_sel_we;
          w_wr_en_d      = w_sel_we;
        end
      end
      StIssue: begin
        w_cnt_d = '0;
      end
      StWait: begin
        // Completion takes priority over a timeout landing in the same cycle.
        if (rf_access_complete) begin
          w_ack_d   = w_ack_vec;
          w_rdata_d = (rf_invalid_address || r_we) ? '0 : rf_read_data;
          w_err_d   = rf_invalid_address;
          w_tout_d  = 1'b0;
        end else if (w_timeout) begin
          w_ack_d   = w_ack_vec;
          w_rdata_d = '0;
          w_err_d   = 1'b0;
          w_tout_d  = 1'b1;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StResp: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_grant      <= 1'b0;
      r_we         <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_ack        <= 2'b00;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_tout       <= 1'b0;
      r_busy       <= 1'b0;
      r_addr       <= '0;
      r_rd_en      <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wdata      <= '0;
    end else begin
      r_grant      <= w_grant_d;
      r_we         <= w_we_d;
      r_last_grant <= w_last_grant_d;
      r_cnt        <= w_cnt_d;
      r_ack        <= w_ack_d;
      r_rdata      <= w_rdata_d;
      r_err        <= w_err_d;
      r_tout       <= w_tout_d;
      r_busy       <= w_busy_d;
      r_addr       <= w_addr_d;
      r_rd_en      <= w_rd_en_d;
      r_wr_en      <= w_wr_en_d;
      r_wdata      <= w_wdata_d;
    end
  end

  assign m_ack         = r_ack;
  assign m_rdata       = r_rdata;
  assign m_err         = r_err;
  assign m_tout        = r_tout;
  assign busy          = r_busy;
  assign rf_address    = r_addr;
  assign rf_read_en    = r_rd_en;
  assign rf_write_en   = r_wr_en;
  assign rf_write_data = r_wdata;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Scoreboard bench for rf_access_arbiter: two requester threads, a behavioural RF responder that
// predicts each response at strobe time, and a monitor that checks every ack against the queue.
`timescale 1ns/1ps
module tb_rf_access_arbiter;
  localparam int AW  = 9;
  localparam int DW  = 32;
  localparam int TO  = 8;
  localparam int TOW = 4;

  logic clk = 1'b0;
  logic res_n = 1'b0;

  // Per-requester request and the RF behaviour it wants to see (latency > TO means never).
  logic          rq_req[2];
  logic          rq_we[2];
  logic [AW-1:0] rq_addr[2];
  logic [DW-1:0] rq_wdata[2];
  int            rq_lat[2];
  logic          rq_inv[2];
  logic [DW-1:0] rq_rdata[2];

  logic [1:0]      m_req, m_we, m_ack;
  logic [2*AW-1:0] m_addr;
  logic [2*DW-1:0] m_wdata;
  logic [DW-1:0]   m_rdata, rf_write_data, rf_read_data;
  logic            m_err, m_tout, busy, rf_read_en, rf_write_en;
  logic [AW-1:0]   rf_address;
  logic            rf_invalid_address, rf_access_complete;

  assign m_req   = {rq_req[1], rq_req[0]};
  assign m_we    = {rq_we[1], rq_we[0]};
  assign m_addr  = {rq_addr[1], rq_addr[0]};
  assign m_wdata = {rq_wdata[1], rq_wdata[0]};

  rf_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .TO_W(TOW)) dut (
    .clk(clk), .res_n(res_n), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .m_err(m_err), .m_tout(m_tout), .busy(busy),
    .rf_address(rf_address), .rf_read_en(rf_read_en), .rf_write_en(rf_write_en),
    .rf_write_data(rf_write_data), .rf_read_data(rf_read_data),
    .rf_invalid_address(rf_invalid_address), .rf_access_complete(rf_access_complete)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  logic [1:0] req_smp = 2'b00;
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    req_smp <= m_req;
  end

  typedef struct {
    logic [1:0]    ack;
    logic [DW-1:0] rdata;
    logic          err;
    logic          tout;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  logic          grants[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            acks = 0;
  int            last_strobe = -1;
  logic          last_who = 1'b1;
  logic [DW-1:0] last_rdata = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Raise a request, wait (bounded) for its ack, drop it on the edge ending the ack cycle.
  task automatic issue(input int i, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input int lat, input logic inv,
                       input logic [DW-1:0] rd, output int raise_cyc);
    logic got;
    rq_we[i] = we; rq_addr[i] = a; rq_wdata[i] = wd;
    rq_lat[i] = lat; rq_inv[i] = inv; rq_rdata[i] = rd;
    rq_req[i] = 1'b1;
    raise_cyc = cyc;
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      got = m_ack[i];
    end
    chk($sformatf("ack_wait_m%0d", i), {63'd0, got}, 64'd1);
    @(posedge clk); #1;
    rq_req[i] = 1'b0;
    @(posedge clk); #1;
  endtask

  // RF responder: predicts grant and response whenever a strobe appears.
  initial begin : rf_model
    logic who, to;
    int lat;
    exp_t e;
    logic [AW-1:0] a0;
    rf_access_complete = 1'b0; rf_read_data = '0; rf_invalid_address = 1'b0;
    forever begin
      @(negedge clk);
      if (res_n && (rf_read_en || rf_write_en)) begin
        who = (req_smp == 2'b11) ? ~last_who : req_smp[1];
        chk("grant_had_req", {63'd0, req_smp[who]}, 64'd1);
        last_who = who;
        grants.push_back(who);
        chk("strobe_kind", {62'd0, rf_read_en, rf_write_en}, rq_we[who] ? 64'd1 : 64'd2);
        chk("rf_address", {55'd0, rf_address}, {55'd0, rq_addr[who]});
        chk("rf_write_data", {32'd0, rf_write_data}, {32'd0, rq_wdata[who]});
        chk("busy_in_access", {63'd0, busy}, 64'd1);
        chk("rdata_held", {32'd0, m_rdata}, {32'd0, last_rdata});
        lat = rq_lat[who];
        to  = (lat > TO);
        e.ack   = who ? 2'b10 : 2'b01;
        e.err   = !to && rq_inv[who];
        e.tout  = to;
        e.rdata = (to || rq_inv[who] || rq_we[who]) ? '0 : rq_rdata[who];
        e.cyc   = cyc + (to ? TO : lat) + 1;
        sb.push_back(e);
        last_strobe = cyc;
        a0 = rf_address;
        if ($urandom_range(3) == 0) begin  // stale completion during ISSUE must be ignored
          rf_access_complete = 1'b1; rf_read_data = $urandom; rf_invalid_address = 1'b1;
        end
        @(posedge clk); #1;
        rf_access_complete = 1'b0;
        for (int w = 1; w <= TO; w++) begin
          if (w == lat) begin
            rf_access_complete = 1'b1;
            rf_read_data = rq_rdata[who];
            rf_invalid_address = rq_inv[who];
          end else begin
            rf_read_data = $urandom;
            rf_invalid_address = 1'($urandom_range(1));
          end
          @(negedge clk);
          if (!res_n) break;
          chk("no_strobe_in_wait", {62'd0, rf_read_en, rf_write_en}, 64'd0);
          chk("addr_held", {55'd0, rf_address}, {55'd0, a0});
          @(posedge clk); #1;
          rf_access_complete = 1'b0;
          if (w == lat) break;
        end
        rf_access_complete = 1'b0;
      end
    end
  end

  // Monitor: every ack pops one prediction.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (m_ack != 2'b00) begin
        acks++;
        if (sb.size() == 0) begin
          chk("ack_unexpected", {62'd0, m_ack}, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("ack_port", {62'd0, m_ack}, {62'd0, e.ack});
          chk("m_rdata", {32'd0, m_rdata}, {32'd0, e.rdata});
          chk("m_err", {63'd0, m_err}, {63'd0, e.err});
          chk("m_tout", {63'd0, m_tout}, {63'd0, e.tout});
          chk("ack_cycle", 64'(cyc), 64'(e.cyc));
          last_rdata = e.rdata;
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, {62'd0, m_ack}, 64'd0);
    chk({tag, "_rdata"}, {32'd0, m_rdata}, 64'd0);
    chk({tag, "_err_tout_busy"}, {61'd0, m_err, m_tout, busy}, 64'd0);
    chk({tag, "_strobes"}, {62'd0, rf_read_en, rf_write_en}, 64'd0);
    chk({tag, "_rf_addr"}, {55'd0, rf_address}, 64'd0);
    chk({tag, "_rf_wdata"}, {32'd0, rf_write_data}, 64'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int rc, rc0, rc1, acks0;
    for (int i = 0; i < 2; i++) begin
      rq_req[i] = 1'b0; rq_we[i] = 1'b0; rq_addr[i] = '0; rq_wdata[i] = '0;
      rq_lat[i] = 1; rq_inv[i] = 1'b0; rq_rdata[i] = '0;
    end
    repeat (3) @(posedge clk);
    #2;
    chk_all_zero("reset");
    @(posedge clk); #1;
    res_n = 1'b1;

    // Both requesters from reset, each twice: m0 must win the first conflict.
    fork
      begin
        issue(0, 1'b1, 9'h010, 32'h1234_5678, 2, 1'b0, 32'h0, rc0);
        issue(0, 1'b1, 9'h010, 32'h1234_5678, 1, 1'b0, 32'h0, rc0);
      end
      begin
        issue(1, 1'b0, 9'h011, 32'h0, 1, 1'b0, 32'hA5A5_0011, rc1);
        issue(1, 1'b0, 9'h011, 32'h0, 3, 1'b0, 32'h5A5A_0011, rc1);
      end
    join
    chk("rr_order_len", 64'(grants.size()), 64'd4);
    chk("rr_order", {60'd0, grants[0], grants[1], grants[2], grants[3]}, 64'b0101);

    // Plain m0 read, completion two cycles after the strobe.
    issue(0, 1'b0, 9'h005, 32'h0, 2, 1'b0, 32'hDEAD_BEEF, rc);
    chk("read_strobe_latency", 64'(last_strobe), 64'(rc + 1));

    // m1 read of an invalid address.
    issue(1, 1'b0, 9'h1FF, 32'h0, 1, 1'b1, 32'hFFFF_FFFF, rc);

    // RF never completes -> timeout, then a normal access.
    issue(0, 1'b0, 9'h0AB, 32'h0, TO + 1, 1'b0, 32'h1111_2222, rc);
    issue(0, 1'b0, 9'h0AC, 32'h0, 1, 1'b0, 32'h3333_4444, rc);
    chk("after_timeout_latency", 64'(last_strobe), 64'(rc + 1));

    // Completion on the last WAIT cycle beats the timeout.
    issue(1, 1'b0, 9'h123, 32'h0, TO, 1'b0, 32'hCAFE_F00D, rc);

    // Reset mid-WAIT.
    rq_we[0] = 1'b0; rq_addr[0] = 9'h0AA; rq_wdata[0] = 32'h7777_7777;
    rq_lat[0] = TO + 1; rq_inv[0] = 1'b0; rq_rdata[0] = 32'h8888_8888;
    rq_req[0] = 1'b1;
    repeat (4) @(posedge clk);
    #3;
    res_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    sb.delete();
    rq_req[0] = 1'b0;
    last_who = 1'b1;
    last_rdata = '0;
    repeat (2) @(posedge clk); #1;
    res_n = 1'b1;
    acks0 = acks;
    repeat (15) @(posedge clk); #1;
    chk("no_ack_after_reset", 64'(acks - acks0), 64'd0);
    issue(0, 1'b0, 9'h0AA, 32'h0, 2, 1'b0, 32'h0BAD_CAFE, rc);
    chk("post_reset_latency", 64'(last_strobe), 64'(rc + 1));

    // Randomised traffic from both requesters.
    fork
      for (int k = 0; k < 25; k++) begin
        int r;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        issue(0, 1'($urandom_range(1)), 9'($urandom), $urandom, $urandom_range(1, TO + 1),
              ($urandom_range(7) == 0), $urandom, r);
      end
      for (int k = 0; k < 25; k++) begin
        int r;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        issue(1, 1'($urandom_range(1)), 9'($urandom), $urandom, $urandom_range(1, TO + 1),
              ($urandom_range(7) == 0), $urandom, r);
      end
    join

    repeat (5) @(posedge clk); #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
